// File: rtl/weightbank_pkg.sv
// Shared constants, state encoding and helpers for the skewed weight bank array
// and the loader that feeds it.
package weightbank_pkg;

  localparam int N      = 40;
  localparam int NDATA  = 24;
  localparam int NADDR  = 9;
  localparam int LANE_W = NDATA;
  localparam int CNT_W  = $clog2(N);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [NADDR:0]   ROW_ONE  = (NADDR + 1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    LAUNCH = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // Row addresses wrap modulo the bank depth.
  function automatic logic [NADDR-1:0] row_addr(input logic [NADDR-1:0] base,
                                                input logic [NADDR-1:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/weight_lane_skew.sv
// Token chain plus lane registers: lane k copies its fill-buffer word k cycles
// after a launch, matching the write-enable skew inside the bank array.
module weight_lane_skew
  import weightbank_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       launch,
  input  logic [N-1:0][LANE_W-1:0]   row_data,
  output logic [N-1:0][LANE_W-1:0]   lanes,
  output logic                       lane_tail
);

  logic [N-1:0] token;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      token <= '0;
    end else begin
      token <= {token[N-2:0], launch};
    end
  end

  // Lane 0 loads on the launch edge itself; lane k follows token bit k-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lanes <= '0;
    end else begin
      if (launch) begin
        lanes[0] <= row_data[0];
      end
      for (int k = 1; k < N; k++) begin
        if (token[k-1]) begin
          lanes[k] <= row_data[k];
        end
      end
    end
  end

  // High during the first cycle in which the last lane holds the new row.
  assign lane_tail = token[N-1];

endmodule

// File: rtl/weight_loader.sv
// Writer-side front end of the skewed weight RAM: gathers N stream words per
// row and launches each row into the bank array with per-lane skew.
module weight_loader
  import weightbank_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [NADDR-1:0]      cfg_base,
  input  logic [NADDR:0]        cfg_rows,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [NDATA-1:0]      s_data,
  output logic [NDATA*N-1:0]    wb_in,
  output logic [NADDR-1:0]      wb_wraddr,
  output logic                  wb_wren,
  output logic                  busy,
  output logic                  done
);

  state_t                   state, state_nxt;
  logic [NADDR-1:0]         base_q, wraddr_q;
  logic [NADDR:0]           rows_q, row_idx, row_nxt;
  logic [CNT_W-1:0]         fill_cnt, wr_idx;
  logic [N-1:0][NDATA-1:0]  fill_buf;
  logic [N-1:0][NDATA-1:0]  lanes;
  logic                     ready_c, accept, launch, last_row, lane_tail, done_q;

  assign row_nxt  = row_idx + ROW_ONE;
  assign last_row = (row_nxt == rows_q);
  // During the launch cycle the buffer is already free at slot 0.
  assign wr_idx   = (state == LAUNCH) ? '0 : fill_cnt;
  assign accept   = s_valid & ready_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start && cfg_rows != '0) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        ready_c = 1'b1;
        if (s_valid && fill_cnt == LAST_IDX) begin
          launch    = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        ready_c   = !last_row;
        state_nxt = last_row ? DRAIN : FILL;
      end
      DRAIN: begin
        if (lane_tail) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q   <= '0;
      rows_q   <= '0;
      row_idx  <= '0;
      fill_cnt <= '0;
      wraddr_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == IDLE && cfg_start && cfg_rows == '0) ||
                (state == DRAIN && lane_tail);
      if (state == IDLE && cfg_start) begin
        base_q   <= cfg_base;
        rows_q   <= cfg_rows;
        row_idx  <= '0;
        fill_cnt <= '0;
      end else if (state == LAUNCH) begin
        row_idx  <= row_nxt;
        fill_cnt <= accept ? CNT_ONE : '0;
      end else if (accept) begin
        fill_cnt <= fill_cnt + CNT_ONE;
      end
      if (launch) begin
        wraddr_q <= row_addr(base_q, row_idx[NADDR-1:0]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_buf <= '0;
    end else if (accept) begin
      fill_buf[wr_idx] <= s_data;
    end
  end

  weight_lane_skew u_skew (
    .clk       (clk),
    .rst       (rst),
    .launch    (launch),
    .row_data  (fill_buf),
    .lanes     (lanes),
    .lane_tail (lane_tail)
  );

  assign wb_in     = lanes;
  assign wb_wraddr = wraddr_q;
  assign wb_wren   = (state == LAUNCH);
  assign busy      = (state != IDLE);
  assign s_ready   = ready_c;
  assign done      = done_q;

endmodule

// File: tb/tb_weight_loader.sv
// Randomized bench for weight_loader: a row-level reference model predicts
// launches, addresses, lane contents and job status every cycle.
module tb_weight_loader;
  import weightbank_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_start;
  logic [NADDR-1:0]      cfg_base;
  logic [NADDR:0]        cfg_rows;
  logic                  s_valid;
  logic                  s_ready;
  logic [NDATA-1:0]      s_data;
  logic [NDATA*N-1:0]    wb_in;
  logic [NADDR-1:0]      wb_wraddr;
  logic                  wb_wren;
  logic                  busy;
  logic                  done;

  weight_loader dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_base  (cfg_base),
    .cfg_rows  (cfg_rows),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .wb_in     (wb_in),
    .wb_wraddr (wb_wraddr),
    .wb_wren   (wb_wren),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;
  int validPct = 100;

  // Reference model state: a job is a list of rows, each row N stream words.
  logic [NDATA-1:0] stimQ[$];
  logic [NDATA-1:0] words[$];
  logic [NDATA-1:0] mLane [N];
  logic [NADDR-1:0] mWraddr;
  int  lAt[$];
  int  lRow[$];
  bit  jobActive;
  int  jBase, jRows, acc, launched;
  int  mLaunchAt, mDoneAt;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelClear();
    stimQ.delete(); words.delete(); lAt.delete(); lRow.delete();
    for (int k = 0; k < N; k++) mLane[k] = '0;
    mWraddr = '0; jobActive = 0; acc = 0; launched = 0;
    jBase = 0; jRows = 0; mLaunchAt = -1; mDoneAt = -1;
  endtask

  task automatic stepCycle(input bit start, input logic [NADDR-1:0] base, input logic [NADDR:0] rows);
    int d;
    bit expReady;
    @(negedge clk);
    cyc++;
    if (mLaunchAt == cyc) begin
      lAt.push_back(cyc);
      lRow.push_back(launched);
      mWraddr = NADDR'((jBase + launched) % (1 << NADDR));
      launched++;
      if (launched == jRows) mDoneAt = cyc + N;
    end
    foreach (lAt[i]) begin
      d = cyc - lAt[i];
      if (d >= 0 && d < N) mLane[d] = words[lRow[i]*N + d];
    end
    if (mDoneAt == cyc) jobActive = 0;
    checkOutput("wb_wren", wb_wren, (mLaunchAt == cyc));
    checkOutput("wb_wraddr", wb_wraddr, mWraddr);
    checkOutput("done", done, (mDoneAt == cyc));
    checkOutput("busy", busy, jobActive);
    for (int k = 0; k < N; k++)
      checkOutput($sformatf("lane%0d", k), wb_in[k*NDATA +: NDATA], mLane[k]);
    expReady = jobActive && (acc < jRows*N) && (acc < (launched + 1)*N);
    if (!jobActive || acc < jRows*N) checkOutput("s_ready", s_ready, expReady);

    cfg_start = start;
    cfg_base  = base;
    cfg_rows  = rows;
    if (stimQ.size() > 0 && $urandom_range(99) < validPct) begin
      s_valid = 1'b1;
      s_data  = stimQ[0];
    end else begin
      s_valid = 1'b0;
      s_data  = NDATA'($urandom);
    end

    if (start && !jobActive) begin
      if (rows == '0) begin
        mDoneAt = cyc + 1;
      end else begin
        jobActive = 1; jBase = int'(base); jRows = int'(rows);
        acc = 0; launched = 0;
        lAt.delete(); lRow.delete(); words.delete();
      end
    end
    if (s_valid && s_ready) begin
      words.push_back(stimQ.pop_front());
      acc++;
      if (acc % N == 0) mLaunchAt = cyc + 1;
    end
  endtask

  task automatic applyReset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_wren", wb_wren, 0);
    checkOutput("rst_wraddr", wb_wraddr, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", s_ready, 0);
    checkOutput("rst_wb_in", |wb_in, 0);
    modelClear();
    cfg_start = 1'b0; s_valid = 1'b0;
    repeat (2) stepCycle(0, '0, '0);
    rst = 1'b1;
  endtask

  task automatic startJob(input int base, input int rows, input int pct, input bit seq);
    for (int i = 0; i < rows*N; i++)
      stimQ.push_back(seq ? NDATA'(i % N + 1) : NDATA'($urandom));
    validPct = pct;
    stepCycle(1, NADDR'(base), (NADDR+1)'(rows));
  endtask

  task automatic runToEnd();
    int budget;
    budget = jRows*N*12 + 200;
    while ((jobActive || mDoneAt > cyc) && budget > 0) begin
      stepCycle(0, '0, '0);
      budget--;
    end
    if (jobActive) checkOutput("timeout", 0, 1);
    repeat (3) stepCycle(0, '0, '0);
  endtask

  task automatic applyStimulus(input int base, input int rows, input int pct, input bit seq);
    startJob(base, rows, pct, seq);
    runToEnd();
  endtask

  initial begin
    int budget;
    rst = 1'b0; cfg_start = 1'b0; cfg_base = '0; cfg_rows = '0;
    s_valid = 1'b0; s_data = '0;
    modelClear();
    applyReset();

    applyStimulus(5, 1, 100, 1);
    applyStimulus(0, 3, 100, 0);
    applyStimulus(300, 2, 50, 0);
    applyStimulus(510, 4, 80, 0);
    applyStimulus(0, 0, 100, 0);

    // Second start while busy must not change the running job.
    startJob(20, 2, 100, 0);
    repeat (15) stepCycle(0, '0, '0);
    stepCycle(1, NADDR'(7), (NADDR+1)'(5));
    runToEnd();

    // Abort during the second of three rows, then reload.
    startJob(0, 3, 100, 0);
    budget = 400;
    while (acc < N + 10 && budget > 0) begin
      stepCycle(0, '0, '0);
      budget--;
    end
    if (acc < N + 10) checkOutput("reach_row2", 0, 1);
    applyReset();
    applyStimulus(100, 1, 70, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
Writer-side front end for the 40-bank skewed weight RAM array.
- Accepts weights as a serial valid/ready stream of 24-bit words, collects one full row of N words, then launches it into the bank array.
- The array delays each bank's write-enable and write-address by one cycle per bank index. This block drives the shared data bus with the matching per-lane skew, so bank k captures row data exactly k cycles after the launch.
- Sits between the host/DMA weight stream and the weight bank's write port.

Parameters:
N, 40, number of RAM banks / lanes per row
NDATA, 24, weight word width
NADDR, 9, bank address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
cfg_start  in  1  one-cycle pulse that starts a load job; ignored while busy=1
cfg_base  in  NADDR  first row address, sampled on cfg_start
cfg_rows  in  NADDR+1  number of rows to load (0..512), sampled on cfg_start
s_valid  in  1  stream word valid
s_ready  out  1  stream word accepted when s_valid & s_ready
s_data  in  NDATA  stream word; word k of a row goes to lane/bank k
wb_in  out  NDATA*N  bank data bus, lane k = bits [(k+1)*NDATA-1 : k*NDATA]
wb_wraddr  out  NADDR  row address for bank 0 (the array skews it for the other banks)
wb_wren  out  1  write enable for bank 0 (the array skews it for the other banks)
busy  out  1  job in progress
done  out  1  one-cycle pulse when the job completes

Behaviour:
- Reset (rst=0, asynchronous): all outputs, all lane registers, the fill buffer, the counters and the token chain go to 0. The state machine goes to IDLE. Reset asserted mid-job aborts the job with no done pulse; partially written rows are not rolled back.
- States:
  - IDLE: cfg_start=1 with cfg_rows>0 goes to FILL, latches base/rows, sets busy=1 on the next cycle. cfg_start=1 with cfg_rows=0 pulses done on the next cycle and stays in IDLE; busy stays 0.
  - FILL: s_ready=1 while the fill count < N. Each accepted word is written to buf[fill_cnt] and fill_cnt increments. When the Nth word is accepted, full is set and s_ready drops.
  - LAUNCH: entered for one cycle (cycle L), the first cycle with full=1.
    - wb_wren=1 and wb_wraddr=(cfg_base + row_idx) mod 2^NADDR, i.e. address wraps.
    - full clears, fill_cnt resets to 0 and row_idx increments.
    - s_ready=1 during L itself, so filling of the next row overlaps the launch.
    - Goes back to FILL, or to DRAIN if row_idx reaches cfg_rows.
  - DRAIN: waits until lane N-1 of the last row is loaded, then pulses done=1 in cycle L_last+N. busy goes to 0 in the same cycle; the block returns to IDLE.
- Lane skew:
  - A one-hot token of length N is injected at the edge entering L and shifts by one lane per clock.
  - lane k <= buf[k] at the edge entering L+k, so lane k holds row r during cycles L+k .. L'+k-1, where L' is the next launch.
  - Lanes not being loaded hold their value.
- Hazard freedom: next-row word k is accepted no earlier than the edge entering L+k+1, after lane k copied buf[k]. The next launch is no earlier than L+N. No gap counter or stall is needed.
- Throughput: one row per N cycles when s_valid is held high. wb_wren is high in exactly one cycle per row and is never high in IDLE or DRAIN.
- s_valid=1 while s_ready=0: no accept, data ignored. A cfg_start while busy has no effect.
- wb_wraddr holds its last value outside launch cycles.

Decomposition:
- Shared package weightbank_pkg holds:
  - constants N, NDATA, NADDR
  - the state encoding (IDLE, FILL, LAUNCH, DRAIN)
  - the lane slice width used by both the bank array and this block
- One natural sub-module, weight_lane_skew: the N-deep token chain plus the N lane registers. Inputs are clk, rst, the launch pulse and buf; output is wb_in.
- The FSM, counters and fill buffer live in the top.

Test Plan:
- Single row: start base=5, rows=1, stream words 1..40 back-to-back.
  - wb_wren=1 for one cycle with wraddr=5.
  - lane k equals k+1 from L+k on.
  - done at L+40; busy low afterwards.
- Back-to-back: rows=3, base=0, s_valid always 1.
  - Launches exactly 40 cycles apart at addresses 0, 1, 2.
  - Lane 0 changes at L1 while lane 39 still shows row 0 until L1+39.
- Backpressure gaps: s_valid toggling 1/0 randomly across rows=2.
  - Each launch occurs only after 40 accepts.
  - Lane contents match the stream order; no word is lost or duplicated.
- Address wrap: base=510, rows=4 -> wraddr sequence 510, 511, 0, 1.
- Edge configs:
  - rows=0 -> done pulse the next cycle, no wb_wren, busy stays 0.
  - cfg_start while busy -> ignored; the job finishes with its original row count.
- Reset mid-job: rst=0 during row 2 of 3.
  - All outputs are 0 immediately (asynchronously) and the block is in IDLE.
  - No done pulse.
  - A new start after reset release loads correctly.
